// File: rtl/ysyx_210544_wb_stage_pkg.sv
// Shared widths, load funct3 codes and the buffered writeback record.
// Also used by memory-stage decode.
package ysyx_210544_wb_stage_pkg;
  localparam int XLEN   = 64;
  localparam int BUS_64 = 64;
  localparam int BUS_32 = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic [4:0]        rd;
    logic              rd_wen;
    logic [XLEN-1:0]   wdata;
    logic [BUS_64-1:0] pc;
    logic [BUS_32-1:0] inst;
    logic              skipcmt;
    logic [BUS_32-1:0] intr_no;
  } wb_rec_t;
endpackage

// File: rtl/ysyx_210544_load_fmt.sv
// Combinational load aligner: shifts the raw doubleword down to the
// addressed byte, then sign/zero-extends according to funct3.
module ysyx_210544_load_fmt
  import ysyx_210544_wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw >> {addr_lo, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   result = shifted;
      F3_LBU:  result = {56'd0, shifted[7:0]};
      F3_LHU:  result = {48'd0, shifted[15:0]};
      F3_LWU:  result = {32'd0, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_210544_wb_stage.sv
// Writeback stage: single-entry buffer between memory stage and commit,
// with load formatting on capture and a retired-instruction counter.
module ysyx_210544_wb_stage
  import ysyx_210544_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_memoryed_req,
  output logic              o_wb_memoryed_ack,
  input  logic [4:0]        i_wb_rd,
  input  logic              i_wb_rd_wen,
  input  logic [XLEN-1:0]   i_wb_alu_data,
  input  logic [XLEN-1:0]   i_wb_mem_data,
  input  logic              i_wb_load,
  input  logic [2:0]        i_wb_funct3,
  input  logic [2:0]        i_wb_addr_lo,
  input  logic [BUS_64-1:0] i_wb_pc,
  input  logic [BUS_32-1:0] i_wb_inst,
  input  logic              i_wb_skipcmt,
  input  logic [BUS_32-1:0] i_wb_intrNo,
  output logic              o_wb_writebacked_req,
  input  logic              i_wb_writebacked_ack,
  output logic [4:0]        o_wb_rd,
  output logic              o_wb_rd_wen,
  output logic [XLEN-1:0]   o_wb_rd_wdata,
  output logic [BUS_64-1:0] o_wb_pc,
  output logic [BUS_32-1:0] o_wb_inst,
  output logic              o_wb_skipcmt,
  output logic [BUS_32-1:0] o_wb_intrNo,
  output logic [XLEN-1:0]   o_wb_instret
);

  logic            valid_q;
  wb_rec_t         rec_q;
  wb_rec_t         rec_d;
  logic [XLEN-1:0] instret_q;
  logic [XLEN-1:0] load_data;
  logic            accept;
  logic            pop;

  ysyx_210544_load_fmt u_load_fmt (
    .raw     (i_wb_mem_data),
    .addr_lo (i_wb_addr_lo),
    .funct3  (i_wb_funct3),
    .result  (load_data)
  );

  assign o_wb_memoryed_ack = !valid_q || i_wb_writebacked_ack;
  assign accept            = i_wb_memoryed_req && o_wb_memoryed_ack;
  assign pop               = valid_q && i_wb_writebacked_ack;

  always_comb begin
    rec_d         = '0;
    rec_d.rd      = i_wb_rd;
    rec_d.rd_wen  = i_wb_rd_wen;
    rec_d.wdata   = i_wb_load ? load_data : i_wb_alu_data;
    rec_d.pc      = i_wb_pc;
    rec_d.inst    = i_wb_inst;
    rec_d.skipcmt = i_wb_skipcmt;
    rec_d.intr_no = i_wb_intrNo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rec_q     <= '0;
      instret_q <= '0;
    end else begin
      if (accept) begin
        rec_q   <= rec_d;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      // An interrupted slot commits but retires no instruction.
      if (pop && (rec_q.intr_no == '0))
        instret_q <= instret_q + 64'd1;
    end
  end

  assign o_wb_writebacked_req = valid_q;
  assign o_wb_rd              = rec_q.rd;
  assign o_wb_rd_wen          = valid_q && rec_q.rd_wen && (rec_q.rd != 5'd0);
  assign o_wb_rd_wdata        = rec_q.wdata;
  assign o_wb_pc              = rec_q.pc;
  assign o_wb_inst            = rec_q.inst;
  assign o_wb_skipcmt         = rec_q.skipcmt;
  assign o_wb_intrNo          = rec_q.intr_no;
  assign o_wb_instret         = instret_q;

endmodule

// File: doc/ysyx_210544_wb_stage.md
Name: ysyx_210544_wb_stage

Overview:
Writeback stage directly upstream of the commit stage. It accepts one memory-stage result per handshake and, for loads, aligns and sign/zero-extends the load data. It holds the result in a single-entry buffer, then presents the register-file write and commit record to the commit stage via a req/ack handshake. It also maintains a retired-instruction counter for the CSR unit.

Parameters:
XLEN, 64, datapath width (fixed; exists only for readability of width rules)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_wb_memoryed_req  input  1  upstream has a valid result
o_wb_memoryed_ack  output  1  stage can accept this cycle
i_wb_rd  input  5  destination register index
i_wb_rd_wen  input  1  destination write enable
i_wb_alu_data  input  64  ALU/CSR result
i_wb_mem_data  input  64  raw 8-byte-aligned doubleword read from memory
i_wb_load  input  1  instruction is a load; select formatted mem data
i_wb_funct3  input  3  load width/sign code
i_wb_addr_lo  input  3  load address bits [2:0]
i_wb_pc  input  64  instruction PC
i_wb_inst  input  32  instruction word
i_wb_skipcmt  input  1  difftest skip flag (MMIO etc.)
i_wb_intrNo  input  32  interrupt number, 0 if none
o_wb_writebacked_req  output  1  buffered result valid
i_wb_writebacked_ack  input  1  commit stage accepts
o_wb_rd  output  5  buffered rd
o_wb_rd_wen  output  1  regfile write strobe
o_wb_rd_wdata  output  64  writeback data
o_wb_pc  output  64  buffered PC
o_wb_inst  output  32  buffered instruction
o_wb_skipcmt  output  1  buffered skip flag
o_wb_intrNo  output  32  buffered interrupt number
o_wb_instret  output  64  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. On rst, all buffered fields are 0, valid=0 and instret=0. Therefore all outputs read 0 except o_wb_memoryed_ack=1.
- Buffer: one entry with a valid bit.
- o_wb_memoryed_ack = !valid | i_wb_writebacked_ack (combinational; allows back-to-back throughput).
- Accept = i_wb_memoryed_req & o_wb_memoryed_ack.
- Pop = valid & i_wb_writebacked_ack.
- Valid update:
  - Accept only: valid<=1.
  - Pop only: valid<=0.
  - Accept and pop in the same cycle: fields reload with the new record and valid stays 1.
  - Neither: hold.
- Latency: 1 cycle from accept to o_wb_writebacked_req=1.
- o_wb_writebacked_req = valid.
- o_wb_rd_wen = valid & rd_wen_q & (rd_q != 0). Writes to x0 are suppressed, but the record still commits.
- Load formatting (computed before capture; buffered value is final):
  - Shift raw data right by addr_lo*8 bits.
  - funct3 000 LB: sign-extend bits [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: sign-extend [31:0].
  - 011 LD: full 64 bits.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - 110 LWU: zero-extend [31:0].
  - 111: result 0.
  - Misalignment is not checked here (trapped upstream).
- i_wb_load=0: wdata = i_wb_alu_data, and funct3/addr_lo are ignored.
- instret increments by 1 on each pop. It wraps modulo 2^64 with no saturation. It does not increment on a pop when the buffered intrNo != 0 (interrupted slot retires nothing).
- Inputs are sampled only on accept. Upstream fields may change freely while ack=0.
- Reset mid-operation: the buffered record is discarded (no commit) and instret clears.

Decomposition:
- Shared defines header holds the BUS_64/BUS_32 widths and funct3 load-code constants (LB..LWU) for use with memory-stage decode.
- One natural sub-module: ysyx_210544_load_fmt, a combinational load aligner (raw data, addr_lo, funct3 -> 64-bit result), also reusable by the memory stage.

Test Plan:
- LB sign: mem_data=64'h8877_6655_4433_2211, addr_lo=7, funct3=000 -> o_wb_rd_wdata=64'hFFFF_FFFF_FFFF_FF88 one cycle after accept.
- LWU/LHU zero: same data, addr_lo=4, funct3=110 -> 64'h0000_0000_8877_6655; addr_lo=2, funct3=101 -> 64'h4433.
- Backpressure: hold i_wb_writebacked_ack=0 with req asserted for 3 cycles -> o_wb_memoryed_ack=0, outputs stable, instret unchanged. Then ack=1 for one cycle -> simultaneous pop and accept, new PC appears next cycle, instret +1.
- x0 write: rd=0, rd_wen=1, alu_data=5 -> o_wb_rd_wen=0, o_wb_writebacked_req=1, instret increments on pop.
- Interrupt slot: intrNo=7 popped -> instret unchanged. Next normal pop -> +1.
- Async reset: assert rst mid-cycle while valid=1 -> o_wb_writebacked_req=0 and o_wb_instret=0 immediately, before the next clk edge.
